// File: rtl/unit_wb_buffer_pkg.sv
// Shared types and defaults for the unit writeback result buffer.
package unit_wb_buffer_pkg;

    localparam int UNIT_WB_BUFFER_DEFAULT_DEPTH = 4;
    localparam int UNIT_WB_XLEN                 = 32;
    localparam int UNIT_WB_ID_W                 = 3;

    typedef logic [UNIT_WB_ID_W-1:0] id_t;

    typedef struct packed {
        id_t                    id;
        logic [UNIT_WB_XLEN-1:0] rd;
    } unit_wb_entry_t;

    function automatic logic is_pow2(input int unsigned v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/unit_wb_buffer_chk.sv
// Protocol and parameter checks for unit_wb_buffer (simulation-only properties).
module unit_wb_buffer_chk
    import unit_wb_buffer_pkg::*;
#(
    parameter int DEPTH = UNIT_WB_BUFFER_DEFAULT_DEPTH
) (
    input logic clk,
    input logic rst_n,
    input logic wb_ack,
    input logic wb_done,
    input logic push,
    input logic pop,
    input logic full,
    input logic empty
);

    if (!is_pow2(DEPTH) || (DEPTH < 2) || (DEPTH > 16)) begin : g_bad_depth
        $error("unit_wb_buffer: DEPTH must be a power of two in 2..16");
    end

    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n) !(push && full))
        else $error("unit_wb_buffer: push while full");

    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) !(pop && empty))
        else $error("unit_wb_buffer: pop while empty");

    a_ack_idle: assert property (@(posedge clk) disable iff (!rst_n) !(wb_ack && !wb_done))
        else $error("unit_wb_buffer: wb_ack with no result presented");

endmodule

// File: rtl/wb_result_fifo.sv
// Generic in-order circular FIFO: head data, occupancy count, full/empty, sync flush.
module wb_result_fifo
    import unit_wb_buffer_pkg::*;
#(
    parameter int  DEPTH   = UNIT_WB_BUFFER_DEFAULT_DEPTH,
    parameter type entry_t = unit_wb_entry_t
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  entry_t                   push_data,
    output entry_t                   head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    entry_t          mem_r [DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;

    // Pointer, storage and occupancy update; flush overrides any push or pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign head_data = mem_r[rd_ptr_r];
    assign count     = count_r;
    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == CW'(0));

endmodule

// File: rtl/unit_wb_buffer.sv
// Writeback-side result buffer for multi-cycle units; holds results until the arbiter acks.
// Optional zero-latency empty bypass under `define UNIT_WB_BUFFER_BYPASS_EN.
module unit_wb_buffer
    import unit_wb_buffer_pkg::*;
#(
    parameter int DEPTH = UNIT_WB_BUFFER_DEFAULT_DEPTH,
    parameter int XLEN  = UNIT_WB_XLEN,
    parameter int ID_W  = UNIT_WB_ID_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ID_W-1:0]        in_id,
    input  logic [XLEN-1:0]        in_rd,
    output logic                   wb_done,
    output logic [ID_W-1:0]        wb_id,
    output logic [XLEN-1:0]        wb_rd,
    input  logic                   wb_ack,
    output logic [$clog2(DEPTH):0] occupancy
);

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [XLEN-1:0] rd;
    } entry_t;

    entry_t                 push_data_s;
    entry_t                 head_data_s;
    logic                   push_s;
    logic                   pop_s;
    logic                   bypass_s;
    logic                   full_s;
    logic                   empty_s;
    logic [$clog2(DEPTH):0] count_s;

    assign push_data_s = {in_id, in_rd};

    // Handshake qualification and result presentation; in_ready only looks at stored state.
    always_comb begin
        bypass_s = 1'b0;
        in_ready = ~full_s;
        wb_done  = ~empty_s;
        wb_id    = head_data_s.id;
        wb_rd    = head_data_s.rd;
`ifdef UNIT_WB_BUFFER_BYPASS_EN
        if (empty_s && in_valid && !flush) begin
            bypass_s = 1'b1;
            wb_done  = 1'b1;
            wb_id    = in_id;
            wb_rd    = in_rd;
        end else begin
            bypass_s = 1'b0;
        end
`endif
        pop_s = wb_ack & ~empty_s;
        if (bypass_s && wb_ack) begin
            push_s = 1'b0;
        end else begin
            push_s = in_valid & ~full_s;
        end
    end

    wb_result_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (push_s),
        .pop       (pop_s),
        .push_data (push_data_s),
        .head_data (head_data_s),
        .count     (count_s),
        .full      (full_s),
        .empty     (empty_s)
    );

    assign occupancy = count_s;

    unit_wb_buffer_chk #(
        .DEPTH (DEPTH)
    ) u_chk (
        .clk     (clk),
        .rst_n   (rst_n),
        .wb_ack  (wb_ack),
        .wb_done (wb_done),
        .push    (push_s),
        .pop     (pop_s),
        .full    (full_s),
        .empty   (empty_s)
    );

endmodule

// File: tb/tb_unit_wb_buffer.sv
// Self-checking bench for unit_wb_buffer: queue reference model plus directed literal checks.
module tb_unit_wb_buffer;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;
    localparam int ID_W  = 3;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [XLEN-1:0] rd;
    } ent_t;

    logic                   clk;
    logic                   rst_n;
    logic                   flush;
    logic                   in_valid;
    logic                   in_ready;
    logic [ID_W-1:0]        in_id;
    logic [XLEN-1:0]        in_rd;
    logic                   wb_done;
    logic [ID_W-1:0]        wb_id;
    logic [XLEN-1:0]        wb_rd;
    logic                   wb_ack;
    logic [$clog2(DEPTH):0] occupancy;

    int   checks;
    int   errors;
    logic chk_en;
    ent_t q[$];

    logic m_byp;
    logic m_done;
    logic m_acc;
    ent_t m_head;

    unit_wb_buffer #(.DEPTH(DEPTH), .XLEN(XLEN), .ID_W(ID_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_id     (in_id),
        .in_rd     (in_rd),
        .wb_done   (wb_done),
        .wb_id     (wb_id),
        .wb_rd     (wb_rd),
        .wb_ack    (wb_ack),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: outputs from the queue contents, then advance the queue for the coming edge.
    always @(negedge clk) begin
        if (chk_en) begin
            if (!rst_n) q.delete();
            m_byp = 1'b0;
`ifdef UNIT_WB_BUFFER_BYPASS_EN
            m_byp = (q.size() == 0) && in_valid && !flush && rst_n;
`endif
            m_done = (q.size() != 0) || m_byp;
            chk("m_wb_done", 64'(wb_done), 64'(m_done));
            chk("m_in_ready", 64'(in_ready), 64'(q.size() < DEPTH));
            chk("m_occupancy", 64'(occupancy), 64'(q.size()));
            if (m_done) begin
                m_head = (q.size() != 0) ? q[0] : ent_t'({in_id, in_rd});
                chk("m_wb_id", 64'(wb_id), 64'(m_head.id));
                chk("m_wb_rd", 64'(wb_rd), 64'(m_head.rd));
            end
            if (rst_n) begin
                if (flush) begin
                    q.delete();
                end else begin
                    m_acc = in_valid && (q.size() < DEPTH) && !(m_byp && wb_ack);
                    if (wb_ack && (q.size() != 0)) void'(q.pop_front());
                    if (m_acc) q.push_back(ent_t'({in_id, in_rd}));
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [ID_W-1:0] id, input logic [XLEN-1:0] rd,
                         input logic ack, input logic fl);
        in_valid = v;
        in_id    = id;
        in_rd    = rd;
        wb_ack   = ack;
        flush    = fl;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 3'd0, 32'd0, 1'b0, 1'b0);
    endtask

    initial begin
        logic v;
        logic fl;
        logic ack;
        checks   = 0;
        errors   = 0;
        chk_en   = 1'b0;
        rst_n    = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        in_id    = '0;
        in_rd    = '0;
        wb_ack   = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk("rst_done", 64'(wb_done), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);
        chk("rst_occ", 64'(occupancy), 64'd0);
        chk("rst_id", 64'(wb_id), 64'd0);
        chk("rst_rd", 64'(wb_rd), 64'd0);
        chk_en = 1'b1;

        // 1: single push, held without ack
        drive(1'b1, 3'd3, 32'hDEADBEEF, 1'b0, 1'b0);
        tick();
        idle();
        for (int c = 0; c < 5; c++) begin
            chk("t1_done", 64'(wb_done), 64'd1);
            chk("t1_id", 64'(wb_id), 64'd3);
            chk("t1_rd", 64'(wb_rd), 64'hDEADBEEF);
            chk("t1_occ", 64'(occupancy), 64'd1);
            tick();
        end
        drive(1'b0, 3'd0, 32'd0, 1'b0, 1'b1);
        tick();

        // 2: fill to full, refuse extra, drain in order
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 3'(i), 32'h100 + 32'(i), 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 3'd4, 32'h104, 1'b0, 1'b0);
        chk("t2_ready_full", 64'(in_ready), 64'd0);
        chk("t2_occ_full", 64'(occupancy), 64'd4);
        tick();
        chk("t2_occ_hold", 64'(occupancy), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i == 0) drive(1'b1, 3'd6, 32'h999, 1'b1, 1'b0);
            else        drive(1'b0, 3'd0, 32'd0, 1'b1, 1'b0);
            chk("t2_order", 64'(wb_id), 64'(i));
            chk("t2_ready", 64'(in_ready), (i == 0) ? 64'd0 : 64'd1);
            tick();
        end
        idle();
        chk("t2_empty", 64'(wb_done), 64'd0);

        // 3: simultaneous push and pop at occupancy 2
        drive(1'b1, 3'd1, 32'hA, 1'b0, 1'b0);
        tick();
        drive(1'b1, 3'd2, 32'hB, 1'b0, 1'b0);
        tick();
        drive(1'b1, 3'd5, 32'hC, 1'b1, 1'b0);
        chk("t3_head", 64'(wb_id), 64'd1);
        tick();
        idle();
        chk("t3_occ", 64'(occupancy), 64'd2);
        chk("t3_head2", 64'(wb_id), 64'd2);
        drive(1'b0, 3'd0, 32'd0, 1'b1, 1'b0);
        tick();
        chk("t3_new", 64'(wb_id), 64'd5);
        drive(1'b0, 3'd0, 32'd0, 1'b1, 1'b0);
        tick();
        idle();

        // 4: flush with concurrent push at occupancy 3
        for (int i = 1; i < 4; i++) begin
            drive(1'b1, 3'(i), 32'h200 + 32'(i), 1'b0, 1'b0);
            tick();
        end
        chk("t4_occ3", 64'(occupancy), 64'd3);
        drive(1'b1, 3'd7, 32'h777, 1'b0, 1'b1);
        tick();
        idle();
        chk("t4_occ", 64'(occupancy), 64'd0);
        chk("t4_done", 64'(wb_done), 64'd0);
        tick();
        chk("t4_done2", 64'(wb_done), 64'd0);

        // 5: asynchronous reset mid-burst
        drive(1'b1, 3'd4, 32'h40, 1'b0, 1'b0);
        tick();
        drive(1'b1, 3'd5, 32'h50, 1'b0, 1'b0);
        tick();
        idle();
        chk("t5_occ2", 64'(occupancy), 64'd2);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_done", 64'(wb_done), 64'd0);
        chk("t5_rst_ready", 64'(in_ready), 64'd1);
        chk("t5_rst_occ", 64'(occupancy), 64'd0);
        tick();
        rst_n = 1'b1;
        drive(1'b1, 3'd6, 32'h21, 1'b0, 1'b0);
        tick();
        idle();
        chk("t5_lat_done", 64'(wb_done), 64'd1);
        chk("t5_lat_id", 64'(wb_id), 64'd6);
        chk("t5_lat_occ", 64'(occupancy), 64'd1);
        drive(1'b0, 3'd0, 32'd0, 1'b1, 1'b0);
        tick();
        idle();

        // 6: empty buffer, new result arriving
`ifdef UNIT_WB_BUFFER_BYPASS_EN
        drive(1'b1, 3'd2, 32'h10, 1'b1, 1'b0);
        chk("t6_byp_done", 64'(wb_done), 64'd1);
        chk("t6_byp_id", 64'(wb_id), 64'd2);
        chk("t6_byp_rd", 64'(wb_rd), 64'h10);
        tick();
        idle();
        chk("t6_byp_occ", 64'(occupancy), 64'd0);
`else
        drive(1'b1, 3'd2, 32'h10, 1'b0, 1'b0);
        chk("t6_done0", 64'(wb_done), 64'd0);
        tick();
        idle();
        chk("t6_done1", 64'(wb_done), 64'd1);
        chk("t6_id", 64'(wb_id), 64'd2);
        drive(1'b0, 3'd0, 32'd0, 1'b1, 1'b0);
        tick();
        idle();
`endif

        // Random traffic against the queue model
        for (int c = 0; c < 1500; c++) begin
            v   = ($urandom_range(3, 0) != 0);
            fl  = ($urandom_range(31, 0) == 0);
            ack = 1'b0;
            if ((q.size() != 0) && ($urandom_range(1, 0) == 1)) ack = 1'b1;
`ifdef UNIT_WB_BUFFER_BYPASS_EN
            if ((q.size() == 0) && v && !fl && ($urandom_range(1, 0) == 1)) ack = 1'b1;
`endif
            drive(v, 3'($urandom), $urandom, ack, fl);
            tick();
        end
        idle();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/unit_wb_buffer.md
Name: unit_wb_buffer

Overview:
- Unit-side producer for the writeback interface (done/id/rd out, ack in).
- Sits at the tail of a multi-cycle execution unit (mul, div, load) and holds completed results until the writeback arbiter acks them.
- Decouples the unit pipeline from arbitration stalls with a small in-order FIFO.

Parameters:
- DEPTH, 4, number of result entries; power of two, 2..16.
- XLEN, 32, result data width (taken from the core config package).
- ID_W, 3, instruction ID width (width of id_t).

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous clear of all buffered results (pipeline flush)
- in_valid  in  1  unit presents a completed result this cycle
- in_ready  out  1  buffer can accept a result this cycle
- in_id  in  ID_W  instruction ID of the incoming result
- in_rd  in  XLEN  result data
- wb_done  out  1  result available to writeback
- wb_id  out  ID_W  ID of the oldest buffered result
- wb_rd  out  XLEN  data of the oldest buffered result
- wb_ack  in  1  writeback consumed the presented result
- occupancy  out  $clog2(DEPTH)+1  number of entries held

Behaviour:
- Reset (rst_n low, asynchronous): read and write pointers 0, count 0. Outputs: wb_done=0, in_ready=1, occupancy=0. wb_id and wb_rd are don't-care but must be deterministic '0.
- Storage:
  - Circular array of DEPTH entries {id, rd}.
  - Pointers are $clog2(DEPTH) bits and wrap naturally at DEPTH-1 -> 0.
  - Count is a separate $clog2(DEPTH)+1-bit register.
- push = in_valid & in_ready. pop = wb_ack & wb_done.
- in_ready = (count != DEPTH). It is registered-state only, with no combinational path from wb_ack, so it is 0 when full even if a pop occurs that cycle.
- wb_done = (count != 0). wb_id and wb_rd come from the entry at the read pointer.
- Latency: a push in cycle N gives wb_done=1 in cycle N+1 when the buffer was empty.
- Ordering: strict FIFO; results leave in arrival order.
- Simultaneous push and pop with 0<count<DEPTH: both pointers advance, count unchanged.
- Empty plus push plus ack in the same cycle: the ack is ignored (wb_done=0) and the push is stored.
- wb_ack while wb_done=0: ignored; an assertion flags it.
- wb_ack held across cycles: each cycle with wb_done=1 pops one entry. The consumer must drop ack after its accepted cycle.
- wb_id and wb_rd must hold stable while wb_done=1 and no ack.
- Flush (synchronous):
  - Next cycle: pointers 0, count 0.
  - Overrides push and pop in the same cycle; a simultaneous in_valid is discarded.
- Reset asserted mid-operation: all entries are dropped immediately (asynchronous), and outputs go to their reset values in the same cycle.
- occupancy = count.
- Assertions: no push when full, no count underflow, and DEPTH is a power of two.

Optional Feature:
- Macro: UNIT_WB_BUFFER_BYPASS_EN.
- Defined:
  - When count==0 and in_valid=1, the input is presented combinationally: wb_done=1, wb_id=in_id, wb_rd=in_rd.
  - If wb_ack=1 that cycle, the result is consumed and not stored (count stays 0).
  - Otherwise it is stored normally.
  - Zero-cycle latency when empty. Flush still discards it.
- Undefined: the one-cycle latency path described above. No combinational path from in_* to wb_*.

Decomposition:
- Shared package: typedef unit_wb_entry_t {id_t id; logic [XLEN-1:0] rd;}, plus constant UNIT_WB_BUFFER_DEFAULT_DEPTH=4.
- Sub-module wb_result_fifo: a generic circular FIFO (push, pop, flush, count, full/empty, head data) parameterised on DEPTH and entry type.
- unit_wb_buffer adds the in_ready/wb_done mapping, the ack qualification, the bypass option and the assertions.

Test Plan:
1. Reset, then push id=3 rd=0xDEADBEEF with no ack. Cycle+1: wb_done=1, wb_id=3, wb_rd=0xDEADBEEF, occupancy=1. These hold stable for 5 cycles.
2. Push ids 0,1,2,3 back-to-back (DEPTH=4) with no ack. After 4 pushes in_ready=0 and occupancy=4; a 5th in_valid is not accepted. Then ack for 4 cycles: ids come out 0,1,2,3 in order, and in_ready=1 from the cycle after the first pop.
3. Steady state with occupancy=2: push id=5 and ack in the same cycle. The oldest pops, id=5 is enqueued, and occupancy stays 2.
4. occupancy=3, then flush=1 together with in_valid id=7. Next cycle: occupancy=0 and wb_done=0; id=7 never appears.
5. rst_n low asynchronously mid-burst (occupancy=2). Same cycle: wb_done=0, in_ready=1. After release, the first push appears with 1-cycle latency and no stale entries.
6. Bypass (UNIT_WB_BUFFER_BYPASS_EN): empty buffer, in_valid id=2 rd=0x10 with wb_ack=1. Same cycle: wb_done=1, wb_id=2; next cycle occupancy=0. Without the macro, wb_done=0 in that cycle and becomes 1 the next.
